// File: rtl/pi_param_pkg.sv
// Shared definitions for the multi-channel PI parameter decoder: command
// field positions, parameter codes, written-slot indices and FSM encoding.
package pi_param_pkg;

  localparam int CODE_HI = 31;
  localparam int CODE_LO = 24;
  localparam int CH_HI   = 23;
  localparam int CH_LO   = 20;
  localparam int PAY_HI  = 15;
  localparam int PAY_LO  = 0;

  localparam logic [7:0] CODE_KP_MSB   = 8'h01;
  localparam logic [7:0] CODE_KP_LSB   = 8'h02;
  localparam logic [7:0] CODE_TI_MSB   = 8'h03;
  localparam logic [7:0] CODE_TI_LSB   = 8'h04;
  localparam logic [7:0] CODE_SETPOINT = 8'h05;
  localparam logic [7:0] CODE_LIMIT_HI = 8'h07;
  localparam logic [7:0] CODE_LIMIT_LO = 8'h08;

  localparam int SLOT_KP_MSB = 0;
  localparam int SLOT_KP_LSB = 1;
  localparam int SLOT_TI_MSB = 2;
  localparam int SLOT_TI_LSB = 3;
  localparam int SLOT_SP     = 4;
  localparam int SLOT_HI     = 5;
  localparam int SLOT_LO     = 6;
  localparam int N_SLOTS     = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_WIPE = 2'd2;

  function automatic logic is_known_code(input logic [7:0] code);
    logic known;
    case (code)
      CODE_KP_MSB, CODE_KP_LSB, CODE_TI_MSB, CODE_TI_LSB,
      CODE_SETPOINT, CODE_LIMIT_HI, CODE_LIMIT_LO: known = 1'b1;
      default:                                     known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/pi_channel_param_regs.sv
// Parameter registers of one PI channel: coefficient shadows with MSB/LSB
// pairing, setpoint, signed limits with ordering check, and written flags.
module pi_channel_param_regs
  import pi_param_pkg::*;
#(
  parameter int SIGNAL_W = 16,
  parameter int COEFF_W  = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [7:0]          code,
  input  logic [15:0]         payload,
  input  logic                dac_stopped,
  input  logic                wipe,
  output logic [COEFF_W-1:0]  kp,
  output logic [COEFF_W-1:0]  ti,
  output logic [SIGNAL_W-1:0] setpoint,
  output logic [SIGNAL_W-1:0] limit_hi,
  output logic [SIGNAL_W-1:0] limit_lo,
  output logic                kp_upd,
  output logic                ti_upd,
  output logic                sp_upd,
  output logic                ready,
  output logic                reject
);

  localparam int UP_W = COEFF_W - 16;

  logic [UP_W-1:0]            pay_up;
  logic signed [SIGNAL_W-1:0] pay_sig;
  logic                       wr_ok;

  logic [COEFF_W-1:0]         kp_q, kp_d, ti_q, ti_d;
  logic [COEFF_W-1:0]         kp_sh_q, kp_sh_d, ti_sh_q, ti_sh_d;
  logic                       kp_pm_q, kp_pm_d, kp_pl_q, kp_pl_d;
  logic                       ti_pm_q, ti_pm_d, ti_pl_q, ti_pl_d;
  logic signed [SIGNAL_W-1:0] sp_q, sp_d, hi_q, hi_d, lo_q, lo_d;
  logic [N_SLOTS-1:0]         written_q, written_d;
  logic                       kp_upd_q, kp_upd_d, ti_upd_q, ti_upd_d, sp_upd_q, sp_upd_d;

  assign pay_up  = payload[UP_W-1:0];
  assign pay_sig = $signed(payload[SIGNAL_W-1:0]);

  // A limit is refused while the DAC runs, or if it would invert an already written pair.
  always_comb begin
    reject = 1'b0;
    if (code == CODE_LIMIT_HI)
      reject = !dac_stopped || (written_q[SLOT_LO] && (pay_sig < lo_q));
    else if (code == CODE_LIMIT_LO)
      reject = !dac_stopped || (written_q[SLOT_HI] && (hi_q < pay_sig));
  end

  assign wr_ok = wr_en && !reject;

  always_comb begin
    kp_d      = kp_q;
    ti_d      = ti_q;
    kp_sh_d   = kp_sh_q;
    ti_sh_d   = ti_sh_q;
    kp_pm_d   = kp_pm_q;
    kp_pl_d   = kp_pl_q;
    ti_pm_d   = ti_pm_q;
    ti_pl_d   = ti_pl_q;
    sp_d      = sp_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    written_d = written_q;
    kp_upd_d  = 1'b0;
    ti_upd_d  = 1'b0;
    sp_upd_d  = 1'b0;
    if (wipe) begin
      kp_d      = '0;
      ti_d      = '0;
      kp_sh_d   = '0;
      ti_sh_d   = '0;
      kp_pm_d   = 1'b0;
      kp_pl_d   = 1'b0;
      ti_pm_d   = 1'b0;
      ti_pl_d   = 1'b0;
      sp_d      = '0;
      hi_d      = '0;
      lo_d      = '0;
      written_d = '0;
      kp_upd_d  = 1'b1;
      ti_upd_d  = 1'b1;
      sp_upd_d  = 1'b1;
    end else begin
      if (wr_ok) begin
        case (code)
          CODE_KP_MSB: begin kp_sh_d[COEFF_W-1:16] = pay_up;  kp_pm_d = 1'b1; end
          CODE_KP_LSB: begin kp_sh_d[15:0]         = payload; kp_pl_d = 1'b1; end
          CODE_TI_MSB: begin ti_sh_d[COEFF_W-1:16] = pay_up;  ti_pm_d = 1'b1; end
          CODE_TI_LSB: begin ti_sh_d[15:0]         = payload; ti_pl_d = 1'b1; end
          CODE_SETPOINT: begin
            sp_d              = pay_sig;
            sp_upd_d          = 1'b1;
            written_d[SLOT_SP] = 1'b1;
          end
          CODE_LIMIT_HI: begin hi_d = pay_sig; written_d[SLOT_HI] = 1'b1; end
          CODE_LIMIT_LO: begin lo_d = pay_sig; written_d[SLOT_LO] = 1'b1; end
          default: ;
        endcase
      end
      // Commit a coefficient only once both halves are in the shadow.
      if (kp_pm_d && kp_pl_d) begin
        kp_d                    = kp_sh_d;
        kp_pm_d                 = 1'b0;
        kp_pl_d                 = 1'b0;
        kp_upd_d                = 1'b1;
        written_d[SLOT_KP_MSB]  = 1'b1;
        written_d[SLOT_KP_LSB]  = 1'b1;
      end
      if (ti_pm_d && ti_pl_d) begin
        ti_d                    = ti_sh_d;
        ti_pm_d                 = 1'b0;
        ti_pl_d                 = 1'b0;
        ti_upd_d                = 1'b1;
        written_d[SLOT_TI_MSB]  = 1'b1;
        written_d[SLOT_TI_LSB]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kp_q      <= '0;
      ti_q      <= '0;
      kp_sh_q   <= '0;
      ti_sh_q   <= '0;
      kp_pm_q   <= 1'b0;
      kp_pl_q   <= 1'b0;
      ti_pm_q   <= 1'b0;
      ti_pl_q   <= 1'b0;
      sp_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      written_q <= '0;
      kp_upd_q  <= 1'b0;
      ti_upd_q  <= 1'b0;
      sp_upd_q  <= 1'b0;
    end else begin
      kp_q      <= kp_d;
      ti_q      <= ti_d;
      kp_sh_q   <= kp_sh_d;
      ti_sh_q   <= ti_sh_d;
      kp_pm_q   <= kp_pm_d;
      kp_pl_q   <= kp_pl_d;
      ti_pm_q   <= ti_pm_d;
      ti_pl_q   <= ti_pl_d;
      sp_q      <= sp_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      written_q <= written_d;
      kp_upd_q  <= kp_upd_d;
      ti_upd_q  <= ti_upd_d;
      sp_upd_q  <= sp_upd_d;
    end
  end

  assign kp       = kp_q;
  assign ti       = ti_q;
  assign setpoint = sp_q;
  assign limit_hi = hi_q;
  assign limit_lo = lo_q;
  assign kp_upd   = kp_upd_q;
  assign ti_upd   = ti_upd_q;
  assign sp_upd   = sp_upd_q;
  assign ready    = &written_q;

endmodule

// File: rtl/pi_param_bank_decoder.sv
// Decodes host command words into per-channel PI parameters; owns the
// IDLE/EVAL/WIPE sequencer, the wipe channel counter and ack/nak/err pulses.
module pi_param_bank_decoder
  import pi_param_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int SIGNAL_W = 16,
  parameter int COEFF_W  = 20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     DAC_stopped,
  input  logic [31:0]              received_data,
  input  logic                     received_control_param_valid,
  input  logic                     wipe_settings,
  output logic                     busy,
  output logic                     ack,
  output logic                     nak,
  output logic                     err,
  output logic [N_CH*COEFF_W-1:0]  pi_kp_coefficient,
  output logic [N_CH*COEFF_W-1:0]  pi_ti_coefficient,
  output logic [N_CH*SIGNAL_W-1:0] pi_setpoint,
  output logic [N_CH*SIGNAL_W-1:0] pi_limit_HI,
  output logic [N_CH*SIGNAL_W-1:0] pi_limit_LO,
  output logic [N_CH-1:0]          pi_kp_update_cmd,
  output logic [N_CH-1:0]          pi_ti_update_cmd,
  output logic [N_CH-1:0]          pi_setpoint_update_cmd,
  output logic [N_CH-1:0]          channel_ready,
  output logic                     control_param_written
);

  logic [1:0]      state_q, state_d;
  logic [7:0]      code_q, code_d;
  logic [3:0]      ch_q, ch_d;
  logic [15:0]     pay_q, pay_d;
  logic [3:0]      wipe_ch_q, wipe_ch_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d, nak_q, nak_d, err_q, err_d;
  logic [N_CH-1:0] ch_wr, ch_wipe, ch_reject;
  logic            code_valid, ch_valid, sel_reject;
  logic            unused_rsvd;

  assign unused_rsvd = ^received_data[19:16];

  always_comb begin
    code_valid = is_known_code(code_q);
    ch_valid   = ({1'b0, ch_q} < 5'(N_CH));
    sel_reject = 1'b0;
    ch_wr      = '0;
    ch_wipe    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == 4'(c)) sel_reject = ch_reject[c];
      ch_wr[c]   = (state_q == ST_EVAL) && code_valid && (ch_q == 4'(c));
      ch_wipe[c] = (state_q == ST_WIPE) && (wipe_ch_q == 4'(c));
    end
  end

  // A wipe request pre-empts a same-cycle strobe, which is dropped silently.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ch_d      = ch_q;
    pay_d     = pay_q;
    wipe_ch_d = wipe_ch_q;
    ack_d     = 1'b0;
    nak_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wipe_settings) begin
          state_d   = ST_WIPE;
          wipe_ch_d = '0;
        end else if (received_control_param_valid) begin
          state_d = ST_EVAL;
          code_d  = received_data[CODE_HI:CODE_LO];
          ch_d    = received_data[CH_HI:CH_LO];
          pay_d   = received_data[PAY_HI:PAY_LO];
        end
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
        if (!code_valid || !ch_valid) nak_d = 1'b1;
        else if (sel_reject)          err_d = 1'b1;
        else                          ack_d = 1'b1;
      end
      ST_WIPE: begin
        wipe_ch_d = wipe_ch_q + 4'd1;
        if (wipe_ch_q == 4'(N_CH - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      ch_q      <= '0;
      pay_q     <= '0;
      wipe_ch_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ch_q      <= ch_d;
      pay_q     <= pay_d;
      wipe_ch_q <= wipe_ch_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      nak_q     <= nak_d;
      err_q     <= err_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pi_channel_param_regs #(
      .SIGNAL_W (SIGNAL_W),
      .COEFF_W  (COEFF_W)
    ) u_regs (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en       (ch_wr[c]),
      .code        (code_q),
      .payload     (pay_q),
      .dac_stopped (DAC_stopped),
      .wipe        (ch_wipe[c]),
      .kp          (pi_kp_coefficient[c*COEFF_W +: COEFF_W]),
      .ti          (pi_ti_coefficient[c*COEFF_W +: COEFF_W]),
      .setpoint    (pi_setpoint[c*SIGNAL_W +: SIGNAL_W]),
      .limit_hi    (pi_limit_HI[c*SIGNAL_W +: SIGNAL_W]),
      .limit_lo    (pi_limit_LO[c*SIGNAL_W +: SIGNAL_W]),
      .kp_upd      (pi_kp_update_cmd[c]),
      .ti_upd      (pi_ti_update_cmd[c]),
      .sp_upd      (pi_setpoint_update_cmd[c]),
      .ready       (channel_ready[c]),
      .reject      (ch_reject[c])
    );
  end

  assign busy                  = busy_q;
  assign ack                   = ack_q;
  assign nak                   = nak_q;
  assign err                   = err_q;
  assign control_param_written = &channel_ready;

endmodule

// File: tb/tb_pi_param_bank_decoder.sv
// Directed bench for pi_param_bank_decoder: responses go through a scoreboard
// queue, parameter buses are checked against a bench-side register model.
module tb_pi_param_bank_decoder;

  localparam int N_CH = 4;
  localparam int SW   = 16;
  localparam int CW   = 20;

  localparam logic [7:0] KPM = 8'h01, KPL = 8'h02, TIM = 8'h03, TIL = 8'h04;
  localparam logic [7:0] SP  = 8'h05, LHI = 8'h07, LLO = 8'h08;
  localparam logic [2:0] R_ACK = 3'b100, R_NAK = 3'b010, R_ERR = 3'b001;

  typedef struct packed {
    logic [2:0] resp;
    logic [3:0] kp;
    logic [3:0] ti;
    logic [3:0] sp;
  } exp_t;

  logic clk, reset_n, DAC_stopped, valid, wipe_settings;
  logic [31:0] received_data;
  logic busy, ack, nak, err, control_param_written;
  logic [N_CH*CW-1:0] kp_bus, ti_bus;
  logic [N_CH*SW-1:0] sp_bus, hi_bus, lo_bus;
  logic [N_CH-1:0] kp_upd, ti_upd, sp_upd, channel_ready;

  logic [N_CH*CW-1:0] m_kp, m_ti;
  logic [N_CH*SW-1:0] m_sp, m_hi, m_lo;
  exp_t sb_q[$];
  int n_chk, n_pass, n_fail;

  pi_param_bank_decoder #(.N_CH(N_CH), .SIGNAL_W(SW), .COEFF_W(CW)) dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .DAC_stopped                  (DAC_stopped),
    .received_data                (received_data),
    .received_control_param_valid (valid),
    .wipe_settings                (wipe_settings),
    .busy                         (busy),
    .ack                          (ack),
    .nak                          (nak),
    .err                          (err),
    .pi_kp_coefficient            (kp_bus),
    .pi_ti_coefficient            (ti_bus),
    .pi_setpoint                  (sp_bus),
    .pi_limit_HI                  (hi_bus),
    .pi_limit_LO                  (lo_bus),
    .pi_kp_update_cmd             (kp_upd),
    .pi_ti_update_cmd             (ti_upd),
    .pi_setpoint_update_cmd       (sp_upd),
    .channel_ready                (channel_ready),
    .control_param_written        (control_param_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_buses(input string tag);
    chk({tag, "_kp"}, kp_bus, m_kp);
    chk({tag, "_ti"}, ti_bus, m_ti);
    chk({tag, "_sp"}, sp_bus, m_sp);
    chk({tag, "_hi"}, hi_bus, m_hi);
    chk({tag, "_lo"}, lo_bus, m_lo);
  endtask

  task automatic send(input logic [7:0] code, input logic [3:0] ch, input logic [15:0] pay,
                      input logic [2:0] r, input logic [3:0] ek, input logic [3:0] et,
                      input logic [3:0] es);
    exp_t e;
    e.resp = r; e.kp = ek; e.ti = et; e.sp = es;
    sb_q.push_back(e);
    @(negedge clk);
    received_data = {code, ch, 4'h0, pay};
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("busy_in_eval", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack || nak || err) break;
    end
    e = sb_q.pop_front();
    chk("resp", {ack, nak, err}, e.resp);
    chk("kp_upd", kp_upd, e.kp);
    chk("ti_upd", ti_upd, e.ti);
    chk("sp_upd", sp_upd, e.sp);
    chk("busy_after", busy, 1'b0);
    @(negedge clk);
    chk("single_pulse", {ack, nak, err, kp_upd, ti_upd, sp_upd}, 15'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    m_kp = '0; m_ti = '0; m_sp = '0; m_hi = '0; m_lo = '0;
    reset_n = 1'b0; DAC_stopped = 1'b0; valid = 1'b0; wipe_settings = 1'b0;
    received_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp", {busy, ack, nak, err}, 4'd0);
    chk("rst_pulses", {kp_upd, ti_upd, sp_upd}, 12'd0);
    chk("rst_ready", {channel_ready, control_param_written}, 5'd0);
    chk_buses("rst");
    reset_n = 1'b1;

    // Coefficient pairing, LSB first.
    send(KPL, 4'd2, 16'h1234, R_ACK, 4'b0000, 4'b0000, 4'b0000);
    chk("kp_before_pair", kp_bus, m_kp);
    send(KPM, 4'd2, 16'h000A, R_ACK, 4'b0100, 4'b0000, 4'b0000);
    m_kp[2*CW +: CW] = 20'hA1234;
    chk_buses("kp_pair");

    // Repeated MSB overwrites the shadow.
    send(TIM, 4'd0, 16'h0003, R_ACK, 4'b0000, 4'b0000, 4'b0000);
    send(TIM, 4'd0, 16'h0005, R_ACK, 4'b0000, 4'b0000, 4'b0000);
    send(TIL, 4'd0, 16'h0BCD, R_ACK, 4'b0000, 4'b0001, 4'b0000);
    m_ti[0 +: CW] = 20'h50BCD;
    chk_buses("ti_pair");

    // Bad code and bad channel.
    send(8'h06, 4'd0, 16'h7777, R_NAK, 4'b0000, 4'b0000, 4'b0000);
    send(SP,    4'd5, 16'h7777, R_NAK, 4'b0000, 4'b0000, 4'b0000);
    chk_buses("nak");

    // Limit rules.
    send(LHI, 4'd1, 16'd300, R_ERR, 4'b0000, 4'b0000, 4'b0000);
    DAC_stopped = 1'b1;
    send(LLO, 4'd1, 16'd100, R_ACK, 4'b0000, 4'b0000, 4'b0000);
    send(LHI, 4'd1, 16'd50,  R_ERR, 4'b0000, 4'b0000, 4'b0000);
    send(LHI, 4'd1, 16'd200, R_ACK, 4'b0000, 4'b0000, 4'b0000);
    send(LLO, 4'd1, 16'd200, R_ACK, 4'b0000, 4'b0000, 4'b0000);
    m_lo[1*SW +: SW] = 16'd200;
    m_hi[1*SW +: SW] = 16'd200;
    chk_buses("limits");

    // Fill all seven slots on every channel.
    for (int c = 0; c < N_CH; c++) begin
      logic [3:0] bit_c;
      logic signed [15:0] lo_v;
      bit_c = 4'(1 << c);
      lo_v  = -16'sd100 - 16'(c);
      send(KPM, 4'(c), 16'(c + 1),        R_ACK, 4'b0000, 4'b0000, 4'b0000);
      send(KPL, 4'(c), 16'h1000 + 16'(c), R_ACK, bit_c,   4'b0000, 4'b0000);
      send(TIM, 4'(c), 16'(c + 2),        R_ACK, 4'b0000, 4'b0000, 4'b0000);
      send(TIL, 4'(c), 16'h2000 + 16'(c), R_ACK, 4'b0000, bit_c,   4'b0000);
      send(SP,  4'(c), 16'h0100 * 16'(c + 1), R_ACK, 4'b0000, 4'b0000, bit_c);
      send(LLO, 4'(c), lo_v,              R_ACK, 4'b0000, 4'b0000, 4'b0000);
      if (c == N_CH - 1) begin
        chk("ready_before_last", channel_ready, 4'b0111);
        chk("cpw_before_last", control_param_written, 1'b0);
      end
      send(LHI, 4'(c), 16'd300 + 16'(c),  R_ACK, 4'b0000, 4'b0000, 4'b0000);
      m_kp[c*CW +: CW] = {4'(c + 1), 16'h1000 + 16'(c)};
      m_ti[c*CW +: CW] = {4'(c + 2), 16'h2000 + 16'(c)};
      m_sp[c*SW +: SW] = 16'h0100 * 16'(c + 1);
      m_lo[c*SW +: SW] = lo_v;
      m_hi[c*SW +: SW] = 16'd300 + 16'(c);
    end
    chk("cpw_after_last", control_param_written, 1'b1);
    chk_buses("full");

    // Wipe with a simultaneous strobe that must be dropped.
    @(negedge clk);
    wipe_settings = 1'b1;
    valid = 1'b1;
    received_data = {SP, 4'd0, 4'h0, 16'h0777};
    @(negedge clk);
    wipe_settings = 1'b0;
    valid = 1'b0;
    chk("wipe_busy0", busy, 1'b1);
    chk("wipe_pulse0", {kp_upd, ti_upd, sp_upd}, 12'd0);
    for (int k = 0; k < N_CH; k++) begin
      logic [3:0] bit_k;
      bit_k = 4'(1 << k);
      @(negedge clk);
      chk("wipe_kp_walk", kp_upd, bit_k);
      chk("wipe_ti_walk", ti_upd, bit_k);
      chk("wipe_sp_walk", sp_upd, bit_k);
      chk("wipe_no_resp", {ack, nak, err}, 3'd0);
      chk("wipe_busy", busy, (k < N_CH - 1));
    end
    @(negedge clk);
    m_kp = '0; m_ti = '0; m_sp = '0; m_hi = '0; m_lo = '0;
    chk("wipe_done", {busy, ack, nak, err, kp_upd, ti_upd, sp_upd}, 16'd0);
    chk("wipe_ready", {channel_ready, control_param_written}, 5'd0);
    chk_buses("wiped");

    // Reset in the middle of a wipe.
    send(SP, 4'd0, 16'h0055, R_ACK, 4'b0000, 4'b0000, 4'b0001);
    send(SP, 4'd3, 16'h0033, R_ACK, 4'b0000, 4'b0000, 4'b1000);
    m_sp[0 +: SW]    = 16'h0055;
    m_sp[3*SW +: SW] = 16'h0033;
    chk("sp_pre_wipe", sp_bus, m_sp);
    @(negedge clk);
    wipe_settings = 1'b1;
    @(negedge clk);
    wipe_settings = 1'b0;
    @(negedge clk);
    chk("wipe2_first", sp_upd, 4'b0001);
    reset_n = 1'b0;
    @(negedge clk);
    m_sp = '0;
    chk("rst_mid_pulses", {kp_upd, ti_upd, sp_upd}, 12'd0);
    chk("rst_mid_busy", busy, 1'b0);
    chk_buses("rst_mid");
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_quiet", {busy, ack, nak, err, kp_upd, ti_upd, sp_upd}, 16'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
